// File: rtl/avalon_arb_pkg.sv
// Shared definitions for the two-master Avalon-MM slave arbiter.
//
// Contents:
//   - DefaultAddrW / DefaultDataW : default slave word-address and data widths
//   - arb_state_e                 : arbiter FSM states (idle, m0 granted, m1 granted)
//   - ArbRoundRobin               : tie-break policy, selected at build time
//   - arb_pick()                  : winner selection from (req0, req1, last_winner)
//
// Build option:
//   ARB_ROUND_ROBIN_EN  defined   -> simultaneous requests alternate away from last winner
//                       undefined -> fixed priority, m0 wins every tie
package avalon_arb_pkg;

  localparam int unsigned DefaultAddrW = 8;
  localparam int unsigned DefaultDataW = 32;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StGnt0 = 2'b01,
    StGnt1 = 2'b10
  } arb_state_e;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit ArbRoundRobin = 1'b1;
`else
  localparam bit ArbRoundRobin = 1'b0;
`endif

  // last_winner: 0 = m0 completed the most recent transfer, 1 = m1 did.
  // Under fixed priority the policy bit masks last_winner, so ties always go to m0.
  function automatic arb_state_e arb_pick(logic req0, logic req1, logic last_winner);
    arb_state_e pick;
    if (req0 && req1) begin
      pick = (ArbRoundRobin && !last_winner) ? StGnt1 : StGnt0;
    end else if (req0) begin
      pick = StGnt0;
    end else if (req1) begin
      pick = StGnt1;
    end else begin
      pick = StIdle;
    end
    return pick;
  endfunction

endpackage

// File: rtl/avalon_slave_arbiter2.sv
// Two-master Avalon-MM arbiter in front of a single Avalon-MM slave.
// m0 is the core data master, m1 the UART debug master. One complete transfer is granted at a
// time; the master that is not granted sees waitrequest=1 and readdata=0.
//
// Ports:
//   clk, reset_n                  : clock, synchronous active-low reset
//   m{0,1}_address_i/read_i/write_i/writedata_i/byteenable_i : master commands
//   m{0,1}_readdata_o, m{0,1}_waitrequest_o                  : master responses
//   s_address_o/read_o/write_o/writedata_o/byteenable_o      : command to the slave
//   s_readdata_i, s_waitrequest_i                            : slave response
//   grant_o                       : one-hot current grant (bit0 = m0, bit1 = m1), 0 when idle
//
// Build option: ARB_ROUND_ROBIN_EN (see avalon_arb_pkg) selects round-robin tie-breaking;
// the default build uses fixed priority with m0 winning ties.
module avalon_slave_arbiter2
  import avalon_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DefaultAddrW,
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic [ADDR_W-1:0]   m0_address_i,
  input  logic                m0_read_i,
  input  logic                m0_write_i,
  input  logic [DATA_W-1:0]   m0_writedata_i,
  input  logic [DATA_W/8-1:0] m0_byteenable_i,
  output logic [DATA_W-1:0]   m0_readdata_o,
  output logic                m0_waitrequest_o,

  input  logic [ADDR_W-1:0]   m1_address_i,
  input  logic                m1_read_i,
  input  logic                m1_write_i,
  input  logic [DATA_W-1:0]   m1_writedata_i,
  input  logic [DATA_W/8-1:0] m1_byteenable_i,
  output logic [DATA_W-1:0]   m1_readdata_o,
  output logic                m1_waitrequest_o,

  output logic [ADDR_W-1:0]   s_address_o,
  output logic                s_read_o,
  output logic                s_write_o,
  output logic [DATA_W-1:0]   s_writedata_o,
  output logic [DATA_W/8-1:0] s_byteenable_o,
  input  logic [DATA_W-1:0]   s_readdata_i,
  input  logic                s_waitrequest_i,

  output logic [1:0]          grant_o
);

  localparam int unsigned BeW = DATA_W / 8;

  arb_state_e state_q, state_d;
  logic       last_winner_q, last_winner_d;
  logic [1:0] grant_q;

  logic req0, req1;

  assign req0 = m0_read_i | m0_write_i;
  assign req1 = m1_read_i | m1_write_i;

  // Next-state logic. A grant lasts exactly one transfer: completion or an aborted request
  // both return to idle, so back-to-back transfers from one master cost one idle cycle and
  // the other master's pending request is looked at in that idle cycle.
  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    unique case (state_q)
      StIdle: begin
        state_d = arb_pick(req0, req1, last_winner_q);
      end
      StGnt0: begin
        if (!req0) begin
          // Master withdrew mid-transfer: nothing completed, history is left alone.
          state_d = StIdle;
        end else if (!s_waitrequest_i) begin
          state_d       = StIdle;
          last_winner_d = 1'b0;
        end
      end
      StGnt1: begin
        if (!req1) begin
          state_d = StIdle;
        end else if (!s_waitrequest_i) begin
          state_d       = StIdle;
          last_winner_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, arbitration history and the registered debug grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      last_winner_q <= 1'b1;
      grant_q       <= 2'b00;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      unique case (state_d)
        StGnt0:  grant_q <= 2'b01;
        StGnt1:  grant_q <= 2'b10;
        default: grant_q <= 2'b00;
      endcase
    end
  end

  assign grant_o = grant_q;

  // Slave command mux: the granted master drives the slave directly, idle drives all zeros.
  always_comb begin
    s_address_o    = '0;
    s_read_o       = 1'b0;
    s_write_o      = 1'b0;
    s_writedata_o  = '0;
    s_byteenable_o = {BeW{1'b0}};
    unique case (state_q)
      StGnt0: begin
        s_address_o    = m0_address_i;
        s_read_o       = m0_read_i;
        s_write_o      = m0_write_i;
        s_writedata_o  = m0_writedata_i;
        s_byteenable_o = m0_byteenable_i;
      end
      StGnt1: begin
        s_address_o    = m1_address_i;
        s_read_o       = m1_read_i;
        s_write_o      = m1_write_i;
        s_writedata_o  = m1_writedata_i;
        s_byteenable_o = m1_byteenable_i;
      end
      default: ;
    endcase
  end

  // Response routing: only the granted master sees the slave; everyone else is stalled.
  always_comb begin
    m0_waitrequest_o = 1'b1;
    m0_readdata_o    = '0;
    m1_waitrequest_o = 1'b1;
    m1_readdata_o    = '0;
    unique case (state_q)
      StGnt0: begin
        m0_waitrequest_o = s_waitrequest_i;
        m0_readdata_o    = s_readdata_i;
      end
      StGnt1: begin
        m1_waitrequest_o = s_waitrequest_i;
        m1_readdata_o    = s_readdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_avalon_slave_arbiter2.sv
// Directed self-checking bench for avalon_slave_arbiter2. The slave is modelled by driving
// s_waitrequest / s_readdata directly. Tie-break expectations follow ARB_ROUND_ROBIN_EN.
module tb_avalon_slave_arbiter2;
  import avalon_arb_pkg::*;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] m0_address, m1_address, s_address;
  logic          m0_read, m0_write, m1_read, m1_write, s_read, s_write;
  logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [3:0]    m0_byteenable, m1_byteenable, s_byteenable;
  logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
  logic          m0_waitrequest, m1_waitrequest, s_waitrequest;
  logic [1:0]    grant;

  int n_checks = 0;
  int n_errors = 0;

  avalon_slave_arbiter2 #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .m0_address_i     (m0_address),
    .m0_read_i        (m0_read),
    .m0_write_i       (m0_write),
    .m0_writedata_i   (m0_writedata),
    .m0_byteenable_i  (m0_byteenable),
    .m0_readdata_o    (m0_readdata),
    .m0_waitrequest_o (m0_waitrequest),
    .m1_address_i     (m1_address),
    .m1_read_i        (m1_read),
    .m1_write_i       (m1_write),
    .m1_writedata_i   (m1_writedata),
    .m1_byteenable_i  (m1_byteenable),
    .m1_readdata_o    (m1_readdata),
    .m1_waitrequest_o (m1_waitrequest),
    .s_address_o      (s_address),
    .s_read_o         (s_read),
    .s_write_o        (s_write),
    .s_writedata_o    (s_writedata),
    .s_byteenable_o   (s_byteenable),
    .s_readdata_i     (s_readdata),
    .s_waitrequest_i  (s_waitrequest),
    .grant_o          (grant)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Move to just after the next rising edge; inputs change here, checks follow after #1.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] tie_exp [4];

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b10; tie_exp[2] = 2'b01; tie_exp[3] = 2'b10;
`else
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b01; tie_exp[2] = 2'b01; tie_exp[3] = 2'b01;
`endif
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation ran past its time budget");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with both masters requesting.
    reset_n       = 1'b0;
    m0_address    = 8'h11; m0_read = 1'b0; m0_write = 1'b1;
    m0_writedata  = 32'hAAAA_AAAA; m0_byteenable = 4'hF;
    m1_address    = 8'h22; m1_read = 1'b1; m1_write = 1'b0;
    m1_writedata  = 32'h5555_5555; m1_byteenable = 4'hF;
    s_readdata    = 32'hDEAD_BEEF;
    s_waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check_eq("rst_s_read", s_read, 1'b0);
      check_eq("rst_s_write", s_write, 1'b0);
      check_eq("rst_m0_wait", m0_waitrequest, 1'b1);
      check_eq("rst_m1_wait", m1_waitrequest, 1'b1);
      check_eq("rst_grant", grant, 2'b00);
    end
    check_eq("rst_m0_rdata", m0_readdata, 32'h0);
    check_eq("rst_s_addr", s_address, 8'h00);
    m0_write = 1'b0;
    m1_read  = 1'b0;
    reset_n  = 1'b1;
    next_cycle();

    // Single zero-wait write from m0.
    m0_address = 8'h03; m0_writedata = 32'h0000_005B; m0_write = 1'b1; m0_byteenable = 4'hF;
    s_waitrequest = 1'b0;
    #1;
    check_eq("wr_idle_grant", grant, 2'b00);
    check_eq("wr_idle_s_write", s_write, 1'b0);
    check_eq("wr_idle_m0_wait", m0_waitrequest, 1'b1);
    next_cycle();
    check_eq("wr_s_write", s_write, 1'b1);
    check_eq("wr_s_addr", s_address, 8'h03);
    check_eq("wr_s_wdata", s_writedata, 32'h0000_005B);
    check_eq("wr_s_be", s_byteenable, 4'hF);
    check_eq("wr_m0_wait", m0_waitrequest, 1'b0);
    check_eq("wr_m1_wait", m1_waitrequest, 1'b1);
    check_eq("wr_grant", grant, 2'b01);
    m0_write = 1'b0;
    next_cycle();
    check_eq("wr_done_grant", grant, 2'b00);
    check_eq("wr_done_s_write", s_write, 1'b0);

    // m1 read with a 3-cycle slave stall.
    m1_address = 8'h07; m1_read = 1'b1; m1_byteenable = 4'h3;
    s_waitrequest = 1'b1;
    s_readdata    = 32'hDEAD_BEEF;
    next_cycle();
    check_eq("rd_s_read", s_read, 1'b1);
    check_eq("rd_s_addr", s_address, 8'h07);
    check_eq("rd_s_be", s_byteenable, 4'h3);
    check_eq("rd_m0_rdata_stall", m0_readdata, 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cycle();
      check_eq("rd_stall_m1_wait", m1_waitrequest, 1'b1);
      check_eq("rd_stall_grant", grant, 2'b10);
      check_eq("rd_stall_m0_wait", m0_waitrequest, 1'b1);
    end
    next_cycle();
    s_waitrequest = 1'b0;
    s_readdata    = 32'h0000_0012;
    #1;
    check_eq("rd_m1_wait", m1_waitrequest, 1'b0);
    check_eq("rd_m1_rdata", m1_readdata, 32'h0000_0012);
    check_eq("rd_m0_rdata", m0_readdata, 32'h0);
    check_eq("rd_m0_wait", m0_waitrequest, 1'b1);
    m1_read = 1'b0;
    next_cycle();
    check_eq("rd_done_grant", grant, 2'b00);
    check_eq("rd_done_s_read", s_read, 1'b0);
    check_eq("rd_done_m1_rdata", m1_readdata, 32'h0);

    // Both masters request continuously; last winner so far is m1.
    m0_address = 8'h01; m0_write = 1'b1; m0_writedata = 32'h0000_0001; m0_byteenable = 4'hF;
    m1_address = 8'h02; m1_read = 1'b1; m1_byteenable = 4'hF;
    s_waitrequest = 1'b0;
    #1;
    check_eq("tie_idle_grant", grant, 2'b00);
    for (int t = 0; t < 4; t++) begin
      next_cycle();
      check_eq("tie_grant", grant, tie_exp[t]);
      check_eq("tie_s_addr", s_address, (tie_exp[t] == 2'b01) ? 8'h01 : 8'h02);
      next_cycle();
      check_eq("tie_gap_grant", grant, 2'b00);
    end
    m0_write = 1'b0;
    m1_read  = 1'b0;
    next_cycle();

    // Abort: m0 granted, slave stalls, m0 withdraws its write.
    m0_address = 8'h05; m0_write = 1'b1;
    s_waitrequest = 1'b1;
    next_cycle();
    check_eq("abort_grant", grant, 2'b01);
    check_eq("abort_s_write", s_write, 1'b1);
    check_eq("abort_m0_wait", m0_waitrequest, 1'b1);
    next_cycle();
    m0_write = 1'b0;
    #1;
    check_eq("abort_drop_s_write", s_write, 1'b0);
    next_cycle();
    check_eq("abort_idle_grant", grant, 2'b00);
    check_eq("abort_idle_s_write", s_write, 1'b0);
    check_eq("abort_idle_m0_wait", m0_waitrequest, 1'b1);
    // History must still name the tie phase's last winner: m1 under round robin, so m0
    // wins the next tie; under fixed priority m0 wins regardless.
    m0_write = 1'b1; m1_read = 1'b1;
    s_waitrequest = 1'b0;
    next_cycle();
    check_eq("abort_lw_grant", grant, 2'b01);
    m0_write = 1'b0; m1_read = 1'b0;
    next_cycle();
    check_eq("abort_lw_done", grant, 2'b00);

    // Reset while m1 is granted and the slave stalls.
    m1_read = 1'b1; m1_address = 8'h09;
    s_waitrequest = 1'b1;
    s_readdata    = 32'h0000_00AB;
    next_cycle();
    check_eq("mrst_grant_pre", grant, 2'b10);
    check_eq("mrst_m1_rdata_pre", m1_readdata, 32'h0000_00AB);
    reset_n = 1'b0;
    next_cycle();
    check_eq("mrst_grant", grant, 2'b00);
    check_eq("mrst_m1_wait", m1_waitrequest, 1'b1);
    check_eq("mrst_s_read", s_read, 1'b0);
    check_eq("mrst_m1_rdata", m1_readdata, 32'h0);
    reset_n = 1'b1;
    m1_read = 1'b0;
    next_cycle();
    // After reset last_winner is m1, so a tie goes to m0 under either policy.
    m0_write = 1'b1; m1_read = 1'b1;
    s_waitrequest = 1'b0;
    next_cycle();
    check_eq("post_rst_tie", grant, 2'b01);
    m0_write = 1'b0; m1_read = 1'b0;
    next_cycle();
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
